// File: rtl/reg_file_pkg.sv
// Shared register-file types and default sizes, common to the ROB, issuer and
// register file.
package reg_file_pkg;

  localparam int REG_IDX_W            = 5;
  localparam int REG_FILE_SIZE        = 32;
  localparam int DEFAULT_ROB_ID_WIDTH = 4;
  localparam int DEFAULT_XLEN         = 32;

  typedef logic [REG_IDX_W-1:0] reg_id_t;

endpackage

// File: rtl/reg_file_if.sv
// Issuer/ROB-facing bus of the register file: commit, flush, rename and the two
// operand lookups.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int ROB_ID_WIDTH = DEFAULT_ROB_ID_WIDTH,
  parameter int XLEN         = DEFAULT_XLEN
);

  logic                    reset_from_rob_bus;
  logic [ROB_ID_WIDTH-1:0] dest_from_rob;
  reg_id_t                 rd_from_rob;
  logic [XLEN-1:0]         value_from_rob;

  logic                    valid_from_issuer;
  reg_id_t                 rd_from_issuer;
  logic [ROB_ID_WIDTH-1:0] dest_from_issuer;
  reg_id_t                 rs1_from_issuer;
  reg_id_t                 rs2_from_issuer;

  logic [ROB_ID_WIDTH-1:0] qj_to_issuer;
  logic [XLEN-1:0]         vj_to_issuer;
  logic [ROB_ID_WIDTH-1:0] qk_to_issuer;
  logic [XLEN-1:0]         vk_to_issuer;

  modport master (
    output reset_from_rob_bus, dest_from_rob, rd_from_rob, value_from_rob,
    output valid_from_issuer, rd_from_issuer, dest_from_issuer,
    output rs1_from_issuer, rs2_from_issuer,
    input  qj_to_issuer, vj_to_issuer, qk_to_issuer, vk_to_issuer
  );

  modport slave (
    input  reset_from_rob_bus, dest_from_rob, rd_from_rob, value_from_rob,
    input  valid_from_issuer, rd_from_issuer, dest_from_issuer,
    input  rs1_from_issuer, rs2_from_issuer,
    output qj_to_issuer, vj_to_issuer, qk_to_issuer, vk_to_issuer
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One operand lookup: x0, then same-cycle commit bypass, then pending tag,
// then the committed value.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_ID_WIDTH = DEFAULT_ROB_ID_WIDTH,
  parameter int XLEN         = DEFAULT_XLEN
) (
  input  reg_id_t                 rs,
  input  logic [ROB_ID_WIDTH-1:0] tag,
  input  logic [XLEN-1:0]         value,
  input  logic [ROB_ID_WIDTH-1:0] commit_dest,
  input  reg_id_t                 commit_rd,
  input  logic [XLEN-1:0]         commit_value,
  output logic [ROB_ID_WIDTH-1:0] q,
  output logic [XLEN-1:0]         v
);

  always_comb begin
    q = '0;
    v = '0;
    if (rs == '0) begin
      q = '0;
      v = '0;
    end else if ((commit_dest != '0) && (commit_rd == rs) && (tag == commit_dest)) begin
      v = commit_value;
    end else if (tag != '0) begin
      q = tag;
    end else begin
      v = value;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags, ROB commit port,
// mispredict flush and two bypassing read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_ID_WIDTH = DEFAULT_ROB_ID_WIDTH,
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int NUM_REGS     = REG_FILE_SIZE
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  reg_file_if.slave bus
);

  logic [XLEN-1:0]         value_q [NUM_REGS];
  logic [XLEN-1:0]         value_d [NUM_REGS];
  logic [ROB_ID_WIDTH-1:0] tag_q   [NUM_REGS];
  logic [ROB_ID_WIDTH-1:0] tag_d   [NUM_REGS];

  logic commit;
  logic rename;
  logic flush;

  assign commit = rdy && (bus.dest_from_rob != '0) && (bus.rd_from_rob != '0);
  assign flush  = rdy && bus.reset_from_rob_bus;
  assign rename = rdy && bus.valid_from_issuer && !bus.reset_from_rob_bus
                  && (bus.rd_from_issuer != '0);

  always_comb begin
    // NOTE: start from the held state so every path assigns every element; no latches.
    value_d = value_q;
    tag_d   = tag_q;

    // Commits arrive in order, so the value always lands; the tag clears only
    // if no younger rename has replaced it.
    if (commit) begin
      value_d[bus.rd_from_rob] = bus.value_from_rob;
      if (tag_q[bus.rd_from_rob] == bus.dest_from_rob) begin
        tag_d[bus.rd_from_rob] = '0;
      end
    end

    // Rename is evaluated after the clear so it wins on a same-register collision.
    if (flush) begin
      tag_d = '{default: '0};
    end else if (rename) begin
      tag_d[bus.rd_from_issuer] = bus.dest_from_issuer;
    end

    value_d[0] = '0;
    tag_d[0]   = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is reset because unwritten registers must read as ready zero.
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking so every flop samples the same pre-edge state.
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  reg_file_read_port #(
    .ROB_ID_WIDTH(ROB_ID_WIDTH),
    .XLEN        (XLEN)
  ) u_rs1_port (
    .rs          (bus.rs1_from_issuer),
    .tag         (tag_q[bus.rs1_from_issuer]),
    .value       (value_q[bus.rs1_from_issuer]),
    .commit_dest (bus.dest_from_rob),
    .commit_rd   (bus.rd_from_rob),
    .commit_value(bus.value_from_rob),
    .q           (bus.qj_to_issuer),
    .v           (bus.vj_to_issuer)
  );

  reg_file_read_port #(
    .ROB_ID_WIDTH(ROB_ID_WIDTH),
    .XLEN        (XLEN)
  ) u_rs2_port (
    .rs          (bus.rs2_from_issuer),
    .tag         (tag_q[bus.rs2_from_issuer]),
    .value       (value_q[bus.rs2_from_issuer]),
    .commit_dest (bus.dest_from_rob),
    .commit_rd   (bus.rd_from_rob),
    .commit_value(bus.value_from_rob),
    .q           (bus.qk_to_issuer),
    .v           (bus.vk_to_issuer)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed scenarios plus randomized traffic against an architectural model of
// the register file.
module tb_reg_file;

  localparam int RW = 4;
  localparam int XL = 32;

  logic clk;
  logic rst;
  logic rdy;

  int pass_cnt;
  int total_cnt;

  logic [XL-1:0] val_m [32];
  logic [RW-1:0] tag_m [32];

  reg_file_if #(.ROB_ID_WIDTH(RW), .XLEN(XL)) bus ();

  reg_file #(.ROB_ID_WIDTH(RW), .XLEN(XL), .NUM_REGS(32)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rdy                    = 1'b1;
    bus.reset_from_rob_bus = 1'b0;
    bus.dest_from_rob      = '0;
    bus.rd_from_rob        = '0;
    bus.value_from_rob     = '0;
    bus.valid_from_issuer  = 1'b0;
    bus.rd_from_issuer     = '0;
    bus.dest_from_issuer   = '0;
    bus.rs1_from_issuer    = '0;
    bus.rs2_from_issuer    = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      val_m[i] = '0;
      tag_m[i] = '0;
    end
  endtask

  // Architectural effect of one clock edge, computed from the current inputs.
  task automatic tick();
    logic [XL-1:0] nv [32];
    logic [RW-1:0] nt [32];
    int rd_c;
    int rd_r;
    nv   = val_m;
    nt   = tag_m;
    rd_c = int'(bus.rd_from_rob);
    rd_r = int'(bus.rd_from_issuer);
    if (rdy) begin
      if (bus.dest_from_rob != 0 && rd_c != 0) begin
        nv[rd_c] = bus.value_from_rob;
        if (tag_m[rd_c] == bus.dest_from_rob) nt[rd_c] = '0;
      end
      if (bus.reset_from_rob_bus) begin
        for (int i = 0; i < 32; i++) nt[i] = '0;
      end else if (bus.valid_from_issuer && rd_r != 0) begin
        nt[rd_r] = bus.dest_from_issuer;
      end
    end
    @(posedge clk);
    val_m = nv;
    tag_m = nt;
    #1;
  endtask

  function automatic void ref_lookup(input logic [4:0] rs, output logic [RW-1:0] q,
                                     output logic [XL-1:0] v);
    q = '0;
    v = '0;
    if (rs == 0) return;
    if (bus.dest_from_rob != 0 && bus.rd_from_rob == rs && tag_m[rs] == bus.dest_from_rob)
      v = bus.value_from_rob;
    else if (tag_m[rs] != 0)
      q = tag_m[rs];
    else
      v = val_m[rs];
  endfunction

  task automatic test_reset();
    idle();
    bus.rs1_from_issuer = 5'd5;
    rst = 1'b1;
    model_clear();
    #3;
    total_cnt++;
    if ({bus.qj_to_issuer, bus.vj_to_issuer, bus.qk_to_issuer, bus.vk_to_issuer} !== '0)
      $display("FAIL reset_held q/v=%h exp=0",
               {bus.qj_to_issuer, bus.vj_to_issuer, bus.qk_to_issuer, bus.vk_to_issuer});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.qj_to_issuer !== 0 || bus.vj_to_issuer !== 0 ||
        bus.qk_to_issuer !== 0 || bus.vk_to_issuer !== 0)
      $display("FAIL reset_lookup qj=%0d vj=%h qk=%0d vk=%h exp=0", bus.qj_to_issuer,
               bus.vj_to_issuer, bus.qk_to_issuer, bus.vk_to_issuer);
    else pass_cnt++;
  endtask

  task automatic test_rename_commit();
    idle();
    bus.valid_from_issuer = 1'b1;
    bus.rd_from_issuer    = 5'd5;
    bus.dest_from_issuer  = 4'd3;
    tick();
    idle();
    bus.rs1_from_issuer = 5'd5;
    #1;
    total_cnt++;
    if (bus.qj_to_issuer !== 4'd3 || bus.vj_to_issuer !== 0)
      $display("FAIL rc_pending qj=%0d vj=%h exp qj=3 vj=0", bus.qj_to_issuer, bus.vj_to_issuer);
    else pass_cnt++;
    bus.dest_from_rob  = 4'd3;
    bus.rd_from_rob    = 5'd5;
    bus.value_from_rob = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if (bus.qj_to_issuer !== 0 || bus.vj_to_issuer !== 32'hDEADBEEF)
      $display("FAIL rc_bypass qj=%0d vj=%h exp qj=0 vj=deadbeef", bus.qj_to_issuer,
               bus.vj_to_issuer);
    else pass_cnt++;
    tick();
    idle();
    bus.rs1_from_issuer = 5'd5;
    #1;
    total_cnt++;
    if (bus.qj_to_issuer !== 0 || bus.vj_to_issuer !== 32'hDEADBEEF)
      $display("FAIL rc_array qj=%0d vj=%h exp qj=0 vj=deadbeef", bus.qj_to_issuer,
               bus.vj_to_issuer);
    else pass_cnt++;
  endtask

  task automatic test_stale_commit();
    idle();
    bus.valid_from_issuer = 1'b1;
    bus.rd_from_issuer    = 5'd7;
    bus.dest_from_issuer  = 4'd2;
    tick();
    bus.dest_from_issuer  = 4'd4;
    tick();
    idle();
    bus.dest_from_rob  = 4'd2;
    bus.rd_from_rob    = 5'd7;
    bus.value_from_rob = 32'h11;
    tick();
    idle();
    bus.rs1_from_issuer = 5'd7;
    #1;
    total_cnt++;
    if (bus.qj_to_issuer !== 4'd4 || bus.vj_to_issuer !== 0)
      $display("FAIL stale_keeps_tag qj=%0d vj=%h exp qj=4 vj=0", bus.qj_to_issuer,
               bus.vj_to_issuer);
    else pass_cnt++;
    bus.dest_from_rob  = 4'd4;
    bus.rd_from_rob    = 5'd7;
    bus.value_from_rob = 32'h22;
    tick();
    idle();
    bus.rs1_from_issuer = 5'd7;
    #1;
    total_cnt++;
    if (bus.qj_to_issuer !== 0 || bus.vj_to_issuer !== 32'h22)
      $display("FAIL stale_final qj=%0d vj=%h exp qj=0 vj=22", bus.qj_to_issuer, bus.vj_to_issuer);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    idle();
    bus.valid_from_issuer = 1'b1;
    bus.rd_from_issuer    = 5'd9;
    bus.dest_from_issuer  = 4'd1;
    tick();
    bus.dest_from_issuer  = 4'd6;
    bus.dest_from_rob     = 4'd1;
    bus.rd_from_rob       = 5'd9;
    bus.value_from_rob    = 32'h55;
    tick();
    idle();
    bus.rs2_from_issuer = 5'd9;
    #1;
    total_cnt++;
    if (bus.qk_to_issuer !== 4'd6 || bus.vk_to_issuer !== 0)
      $display("FAIL same_rename_wins qk=%0d vk=%h exp qk=6 vk=0", bus.qk_to_issuer,
               bus.vk_to_issuer);
    else pass_cnt++;
    bus.reset_from_rob_bus = 1'b1;
    tick();
    idle();
    bus.rs2_from_issuer = 5'd9;
    #1;
    total_cnt++;
    if (bus.qk_to_issuer !== 0 || bus.vk_to_issuer !== 32'h55)
      $display("FAIL same_value_written qk=%0d vk=%h exp qk=0 vk=55", bus.qk_to_issuer,
               bus.vk_to_issuer);
    else pass_cnt++;
  endtask

  task automatic test_x0();
    idle();
    bus.valid_from_issuer = 1'b1;
    bus.rd_from_issuer    = 5'd0;
    bus.dest_from_issuer  = 4'd5;
    bus.dest_from_rob     = 4'd5;
    bus.rd_from_rob       = 5'd0;
    bus.value_from_rob    = 32'hFF;
    #1;
    total_cnt++;
    if (bus.qj_to_issuer !== 0 || bus.vj_to_issuer !== 0)
      $display("FAIL x0_same_cycle qj=%0d vj=%h exp 0", bus.qj_to_issuer, bus.vj_to_issuer);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (bus.qj_to_issuer !== 0 || bus.vj_to_issuer !== 0)
      $display("FAIL x0_after qj=%0d vj=%h exp 0", bus.qj_to_issuer, bus.vj_to_issuer);
    else pass_cnt++;
  endtask

  task automatic rename_x1_to_x3();
    idle();
    bus.valid_from_issuer = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      bus.rd_from_issuer   = 5'(r);
      bus.dest_from_issuer = 4'(r);
      tick();
    end
  endtask

  task automatic test_flush_rdy();
    rename_x1_to_x3();
    idle();
    bus.reset_from_rob_bus = 1'b1;
    bus.valid_from_issuer  = 1'b1;
    bus.rd_from_issuer     = 5'd1;
    bus.dest_from_issuer   = 4'd7;
    tick();
    idle();
    for (int r = 1; r <= 3; r++) begin
      bus.rs1_from_issuer = 5'(r);
      bus.rs2_from_issuer = 5'(r);
      #1;
      total_cnt++;
      if (bus.qj_to_issuer !== 0 || bus.qk_to_issuer !== 0)
        $display("FAIL flush_clears x%0d qj=%0d qk=%0d exp 0", r, bus.qj_to_issuer,
                 bus.qk_to_issuer);
      else pass_cnt++;
    end
    rename_x1_to_x3();
    idle();
    rdy                    = 1'b0;
    bus.reset_from_rob_bus = 1'b1;
    bus.valid_from_issuer  = 1'b1;
    bus.rd_from_issuer     = 5'd1;
    bus.dest_from_issuer   = 4'd7;
    tick();
    idle();
    for (int r = 1; r <= 3; r++) begin
      bus.rs1_from_issuer = 5'(r);
      #1;
      total_cnt++;
      if (bus.qj_to_issuer !== 4'(r))
        $display("FAIL rdy_low_holds x%0d qj=%0d exp=%0d", r, bus.qj_to_issuer, r);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] eq;
    logic [XL-1:0] ev;
    logic [4:0]    r;
    for (int n = 0; n < 400; n++) begin
      rdy                    = ($urandom_range(9) != 0);
      bus.reset_from_rob_bus = ($urandom_range(19) == 0);
      bus.valid_from_issuer  = $urandom_range(1);
      bus.rd_from_issuer     = 5'($urandom_range(7));
      bus.dest_from_issuer   = 4'($urandom_range(15, 1));
      r                      = 5'($urandom_range(7));
      bus.rd_from_rob        = r;
      bus.dest_from_rob      = ($urandom_range(1) != 0) ? tag_m[r] : 4'($urandom_range(15));
      bus.value_from_rob     = $urandom;
      bus.rs1_from_issuer    = 5'($urandom_range(7));
      bus.rs2_from_issuer    = 5'($urandom_range(7));
      #1;
      ref_lookup(bus.rs1_from_issuer, eq, ev);
      total_cnt++;
      if (bus.qj_to_issuer !== eq || bus.vj_to_issuer !== ev)
        $display("FAIL rand_rs1 n=%0d rs=%0d qj=%0d vj=%h exp qj=%0d vj=%h", n,
                 bus.rs1_from_issuer, bus.qj_to_issuer, bus.vj_to_issuer, eq, ev);
      else pass_cnt++;
      ref_lookup(bus.rs2_from_issuer, eq, ev);
      total_cnt++;
      if (bus.qk_to_issuer !== eq || bus.vk_to_issuer !== ev)
        $display("FAIL rand_rs2 n=%0d rs=%0d qk=%0d vk=%h exp qk=%0d vk=%h", n,
                 bus.rs2_from_issuer, bus.qk_to_issuer, bus.vk_to_issuer, eq, ev);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_midop();
    idle();
    bus.valid_from_issuer = 1'b1;
    bus.rd_from_issuer    = 5'd4;
    bus.dest_from_issuer  = 4'd9;
    bus.dest_from_rob     = 4'd2;
    bus.rd_from_rob       = 5'd6;
    bus.value_from_rob    = 32'hABCD;
    #2;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int r = 1; r < 8; r++) begin
      bus.rs1_from_issuer = 5'(r);
      #1;
      total_cnt++;
      if (bus.qj_to_issuer !== 0 || bus.vj_to_issuer !== 0)
        $display("FAIL reset_midop x%0d qj=%0d vj=%h exp 0", r, bus.qj_to_issuer,
                 bus.vj_to_issuer);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    idle();
    model_clear();
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_x0();
    test_flush_rdy();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer, which drives the commit port.
- The issuer uses it in three ways:
  - renames rd to its allocated ROB id;
  - looks up rs1/rs2, receiving either a committed value or the ROB id of the producing entry;
  - forwards that ROB id to the ROB operand query.
- A mispredict flush on the rob bus drops all pending renames.

Parameters:
- ROB_ID_WIDTH, 4, width of ROB entry id. Id 0 means "none / value ready"; valid ids are 1..2^ROB_ID_WIDTH-1.
- XLEN, 32, register data width.
- NUM_REGS, 32, architectural register count (index width 5).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- reset_from_rob_bus  in  1  flush: clear all rename tags.
- dest_from_rob  in  ROB_ID_WIDTH  committing ROB id; 0 = no commit this cycle.
- rd_from_rob  in  5  committing destination register.
- value_from_rob  in  XLEN  committing value.
- valid_from_issuer  in  1  rename request this cycle.
- rd_from_issuer  in  5  register being renamed.
- dest_from_issuer  in  ROB_ID_WIDTH  ROB id allocated to the renaming instruction.
- rs1_from_issuer  in  5  source 1 index.
- rs2_from_issuer  in  5  source 2 index.
- qj_to_issuer  out  ROB_ID_WIDTH  pending producer of rs1; 0 = vj valid.
- vj_to_issuer  out  XLEN  rs1 value; 0 when qj != 0.
- qk_to_issuer  out  ROB_ID_WIDTH  pending producer of rs2; 0 = vk valid.
- vk_to_issuer  out  XLEN  rs2 value; 0 when qk != 0.

Behaviour:
- State:
  - value[0..31], XLEN bits each.
  - tag[0..31], ROB_ID_WIDTH bits each.
  - Register 0 is hardwired: value 0, tag 0, never written.
- Reset (async, rst=1): all value and tag cleared to 0. Outputs are combinational, so all q/v outputs read 0 immediately. Reset mid-operation discards any in-flight rename or commit.
- Lookups are combinational, zero latency, and identical for the rs1 and rs2 ports:
  - rs == 0: q=0, v=0.
  - Else if dest_from_rob != 0, rd_from_rob == rs and tag[rs] == dest_from_rob: bypass with q=0, v=value_from_rob.
  - Else if tag[rs] != 0: q=tag[rs], v=0.
  - Else: q=0, v=value[rs].
  - Lookups never see a same-cycle rename, so an instruction whose rd equals its rs reads the older producer.
- Commit (posedge clk, rdy=1, dest_from_rob != 0, rd_from_rob != 0):
  - value[rd] <= value_from_rob unconditionally, because commits arrive in program order.
  - tag[rd] <= 0 only if tag[rd] == dest_from_rob. A newer rename keeps its tag.
- Rename (posedge clk, rdy=1, valid_from_issuer=1, reset_from_rob_bus=0, rd_from_issuer != 0): tag[rd] <= dest_from_issuer.
- Simultaneous commit and rename to the same rd: the value is written and the tag takes dest_from_issuer (rename wins over the clear).
- Flush (reset_from_rob_bus=1, rdy=1):
  - All tags <= 0.
  - A same-cycle commit value write is still performed.
  - Rename is ignored.
  - Lookups in the flush cycle return pre-flush state and are don't-care to the issuer.
- rdy=0: no state update of any kind, including flush. Lookups remain combinationally valid.
- Id wrap: tags are stored and compared opaquely. The ROB guarantees no live id reuse.

Decomposition:
- Shared config.v holds REG_ID_TYPE [4:0], REG_TYPE [31:0], RO_BUFFER_ID_TYPE (ROB_ID_WIDTH bits), and REG_FILE_SIZE 32. It is the same include used by the ROB and issuer.
- One natural sub-module, reg_file_read_port, implements the lookup/bypass priority for one source. It is instantiated twice (rs1, rs2).
- No new typedefs are needed.

Test Plan:
- Reset then lookup: assert rst, release, rs1=5, rs2=0 -> qj=0, vj=0, qk=0, vk=0.
- Rename then commit: rename x5 -> id 3; next cycle rs1=5 -> qj=3, vj=0. Commit (dest=3, rd=5, value=0xDEADBEEF) with rs1=5 in the same cycle -> bypass qj=0, vj=0xDEADBEEF. Following cycle -> qj=0, vj=0xDEADBEEF from the array.
- Stale commit keeps newer tag: rename x7 -> id 2, then x7 -> id 4, then commit (dest=2, rd=7, value=0x11) -> value[7]=0x11 and rs1=7 returns qj=4. Commit (dest=4, value=0x22) -> qj=0, vj=0x22.
- Same-cycle commit and rename on x9: tag[9]=1, commit (dest=1, rd=9, value=0x55) together with rename (rd=9, dest=6) -> next cycle rs2=9 gives qk=6. After a flush, qk=0, vk=0x55.
- x0 immunity: rename rd=0 -> id 5 and commit (dest=5, rd=0, value=0xFF) -> rs1=0 always gives qj=0, vj=0.
- Flush and rdy:
  - Tags on x1..x3; pulse reset_from_rob_bus with a simultaneous rename x1 -> id 7 -> next cycle all q=0 and x1 is not renamed.
  - Repeat with rdy=0 -> tags unchanged.
